// File: rtl/ifu_fetch.sv
`default_nettype none
// ============================================================================
// Module   : ifu_fetch
// Purpose  : Instruction-fetch stage. Samples the PC, issues one word read on
//            a valid/ready request channel, takes the single response and
//            presents {pc, instr, fault} to decode under valid/ready. Pulses
//            pc_adv when decode takes the instruction; a flush discards any
//            stale request or buffered instruction.
// Revision : 1.0 - initial release
// ============================================================================
module ifu_fetch #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   // PC register interface
   input  logic [ADDR_W-1:0] pc,
   input  logic              flush,
   output logic              pc_adv,
   // Instruction memory request channel
   output logic              imem_req_valid,
   input  logic              imem_req_ready,
   output logic [ADDR_W-1:0] imem_req_addr,
   // Instruction memory response channel
   input  logic              imem_rsp_valid,
   input  logic [DATA_W-1:0] imem_rsp_data,
   input  logic              imem_rsp_err,
   // Decode interface
   output logic              id_valid,
   input  logic              id_ready,
   output logic [ADDR_W-1:0] id_pc,
   output logic [DATA_W-1:0] id_instr,
   output logic              id_fault
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_WAIT = 2'd2,
      S_HOLD = 2'd3
   } state_t;

   state_t            r_state;
   logic              r_drop;     // outstanding response belongs to a flushed path
   logic [ADDR_W-1:0] r_req_pc;   // PC that the outstanding request was issued for

   logic              w_handoff;
   logic              w_misaligned;
   logic              w_req_fire;

   assign w_handoff    = id_valid & id_ready;
   assign w_misaligned = (pc[1:0] != 2'b00);
   assign w_req_fire   = imem_req_valid & imem_req_ready;

   // The PC register steps only when decode takes the instruction and no jump overrides it.
   assign pc_adv = w_handoff & ~flush;

   // Fetch sequencer. REQ has two phases: a sampling cycle (request not yet valid) in which
   // the PC register has already settled after the previous advance/jump, then the request
   // phase in which the address is held until the memory accepts it.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state        <= S_IDLE;
         r_drop         <= 1'b0;
         r_req_pc       <= '0;
         imem_req_valid <= 1'b0;
         imem_req_addr  <= '0;
         id_valid       <= 1'b0;
         id_pc          <= '0;
         id_instr       <= '0;
         id_fault       <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               // Responses arriving here belong to a transaction abandoned by reset.
               r_state <= S_REQ;
            end

            S_REQ: begin
               if (!imem_req_valid) begin
                  // Sampling cycle. A jump this cycle means pc is about to change, so
                  // nothing is issued and the new target is sampled next cycle instead.
                  if (!flush) begin
                     imem_req_addr <= pc;
                     r_req_pc      <= pc;
                     if (w_misaligned) begin
                        // Misaligned PC never reaches memory; report a fetch fault.
                        id_valid <= 1'b1;
                        id_pc    <= pc;
                        id_instr <= '0;
                        id_fault <= 1'b1;
                        r_state  <= S_HOLD;
                     end else begin
                        imem_req_valid <= 1'b1;
                     end
                  end
               end else begin
                  // Request already on the bus: it cannot be withdrawn, so a jump only
                  // marks its response for discard.
                  if (flush) begin
                     r_drop <= 1'b1;
                  end
                  if (w_req_fire) begin
                     imem_req_valid <= 1'b0;
                     r_state        <= S_WAIT;
                  end
               end
            end

            S_WAIT: begin
               if (imem_rsp_valid) begin
                  if (flush || r_drop) begin
                     // Stale response: discard and refetch from the current PC.
                     r_drop  <= 1'b0;
                     r_state <= S_REQ;
                  end else begin
                     id_valid <= 1'b1;
                     id_pc    <= r_req_pc;
                     id_instr <= imem_rsp_data;
                     id_fault <= imem_rsp_err;
                     r_state  <= S_HOLD;
                  end
               end else if (flush) begin
                  r_drop <= 1'b1;
               end
            end

            S_HOLD: begin
               // Either a jump or a handoff retires the buffered instruction; the jump
               // wins the pc_adv decision combinationally.
               if (flush || id_ready) begin
                  id_valid <= 1'b0;
                  r_state  <= S_REQ;
               end
            end

            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   // Memory may only answer the single outstanding request; IDLE tolerates leftovers from reset.
   a_rsp_in_wait : assert property (@(posedge clk) disable iff (rst)
      imem_rsp_valid |-> (r_state == S_WAIT || r_state == S_IDLE));

endmodule
`default_nettype wire

// File: tb/tb_ifu_fetch.sv
`default_nettype none
// ============================================================================
// Module   : tb_ifu_fetch
// Purpose  : Self-checking bench for ifu_fetch. Directed scenarios followed by
//            randomized traffic against a transaction-level PC/memory model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ifu_fetch;

   logic        clk;
   logic        rst;
   logic [31:0] pc;
   logic        flush;
   logic        pc_adv;
   logic        imem_req_valid;
   logic        imem_req_ready;
   logic [31:0] imem_req_addr;
   logic        imem_rsp_valid;
   logic [31:0] imem_rsp_data;
   logic        imem_rsp_err;
   logic        id_valid;
   logic        id_ready;
   logic [31:0] id_pc;
   logic [31:0] id_instr;
   logic        id_fault;

   ifu_fetch #(.ADDR_W(32), .DATA_W(32)) u_dut (
      .clk            (clk),
      .rst            (rst),
      .pc             (pc),
      .flush          (flush),
      .pc_adv         (pc_adv),
      .imem_req_valid (imem_req_valid),
      .imem_req_ready (imem_req_ready),
      .imem_req_addr  (imem_req_addr),
      .imem_rsp_valid (imem_rsp_valid),
      .imem_rsp_data  (imem_rsp_data),
      .imem_rsp_err   (imem_rsp_err),
      .id_valid       (id_valid),
      .id_ready       (id_ready),
      .id_pc          (id_pc),
      .id_instr       (id_instr),
      .id_fault       (id_fault)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_fail = 0;

   // Per-cycle stimulus knobs
   logic        k_flush     = 1'b0;
   logic [31:0] k_target    = '0;
   logic        k_id_ready  = 1'b1;
   logic        k_req_ready = 1'b1;
   int          k_lat       = 0;
   logic        k_stray     = 1'b0;

   // Memory model: one outstanding request
   logic        mem_busy = 1'b0;
   int          mem_cnt  = 0;
   logic [31:0] mem_addr = '0;

   logic        req_pend   = 1'b0;
   logic [31:0] req_addr_q = '0;
   int          n_hand     = 0;
   int          since_hand = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      if (a == 32'h8000_0000) return 32'h0000_0013;
      return {a[15:0], a[31:16]} ^ 32'h5A5A_1234;
   endfunction

   function automatic logic mem_err(input logic [31:0] a);
      return (a[6:2] == 5'd7);
   endfunction

   function automatic logic [31:0] exp_instr(input logic [31:0] a);
      return (a[1:0] != 2'b00) ? 32'h0 : mem_word(a);
   endfunction

   function automatic logic exp_fault(input logic [31:0] a);
      return (a[1:0] != 2'b00) || mem_err(a);
   endfunction

   // One clock cycle, entered and left at the falling edge.
   task automatic tick();
      logic [31:0] pc_nxt;
      logic        hand;
      flush          = k_flush;
      id_ready       = k_id_ready;
      imem_req_ready = k_req_ready;
      if (k_stray || (mem_busy && mem_cnt == 0)) begin
         imem_rsp_valid = 1'b1;
         imem_rsp_data  = mem_word(mem_addr);
         imem_rsp_err   = mem_err(mem_addr);
      end else begin
         imem_rsp_valid = 1'b0;
         imem_rsp_data  = $urandom;
         imem_rsp_err   = 1'($urandom_range(0, 1));
      end
      #1;
      // Any instruction shown to decode must be the one at the architectural PC.
      hand = id_valid && id_ready && !flush;
      chk("pc_adv", pc_adv, hand);
      if (id_valid) begin
         chk("id_pc", id_pc, pc);
         chk("id_instr", id_instr, exp_instr(pc));
         chk("id_fault", id_fault, exp_fault(pc));
      end
      if (imem_req_valid) begin
         chk("req_align", imem_req_addr[1:0], 2'b00);
         chk("one_outstanding", mem_busy, 1'b0);
      end
      if (req_pend) chk("req_hold", {imem_req_valid, imem_req_addr}, {1'b1, req_addr_q});
      req_pend   = imem_req_valid && !imem_req_ready;
      req_addr_q = imem_req_addr;
      // Memory
      if (imem_rsp_valid && !k_stray) mem_busy = 1'b0;
      else if (mem_busy) mem_cnt--;
      if (imem_req_valid && imem_req_ready) begin
         mem_busy = 1'b1;
         mem_addr = imem_req_addr;
         mem_cnt  = k_lat;
      end
      // PC register
      if (flush)     pc_nxt = k_target;
      else if (hand) pc_nxt = pc + 32'd4;
      else           pc_nxt = pc;
      if (hand) begin
         n_hand++;
         since_hand = 0;
      end else begin
         since_hand++;
      end
      @(posedge clk);
      @(negedge clk);
      pc = pc_nxt;
   endtask

   task automatic wait_req(input string tag, output int t, output logic saw_valid);
      t = 0;
      saw_valid = 1'b0;
      while (!imem_req_valid && t < 40) begin
         saw_valid |= id_valid;
         tick();
         t++;
      end
      chk({tag, "_req_seen"}, imem_req_valid, 1'b1);
   endtask

   task automatic wait_valid(input string tag, output int t, output logic saw_req);
      t = 0;
      saw_req = 1'b0;
      while (!id_valid && t < 40) begin
         saw_req |= imem_req_valid;
         tick();
         t++;
      end
      chk({tag, "_valid_seen"}, id_valid, 1'b1);
   endtask

   initial begin
      int          t;
      logic        seen;
      logic [31:0] a0;
      rst            = 1'b1;
      pc             = 32'h8000_0000;
      flush          = 1'b0;
      id_ready       = 1'b0;
      imem_req_ready = 1'b0;
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = '0;
      imem_rsp_err   = 1'b0;
      repeat (2) @(negedge clk);

      // Reset state
      chk("rst_flags", {pc_adv, imem_req_valid, id_valid, id_fault}, 4'h0);
      chk("rst_addr", imem_req_addr, 32'h0);
      chk("rst_id_pc", id_pc, 32'h0);
      chk("rst_id_instr", id_instr, 32'h0);
      rst = 1'b0;

      // Basic fetch and latency, decode stalled
      k_id_ready = 1'b0;
      wait_req("t1", t, seen);
      chk("t1_req_lat", t, 2);
      chk("t1_addr", imem_req_addr, 32'h8000_0000);
      wait_valid("t1", t, seen);
      chk("t1_rsp_lat", t, 2);
      chk("t1_id_pc", id_pc, 32'h8000_0000);
      chk("t1_id_instr", id_instr, 32'h0000_0013);
      chk("t1_id_fault", id_fault, 1'b0);

      // Decode stalled for five cycles: everything holds
      repeat (5) begin
         tick();
         chk("t2_hold", {id_valid, imem_req_valid, pc_adv}, 3'b100);
         chk("t2_id_pc", id_pc, 32'h8000_0000);
      end
      id_ready = 1'b1;
      #1;
      chk("t2_pc_adv", pc_adv, 1'b1);
      k_id_ready = 1'b1;
      tick();
      chk("t2_pc_next", pc, 32'h8000_0004);

      // Flush while waiting for the response
      k_lat = 2;
      wait_req("t3a", t, seen);
      tick();
      k_flush  = 1'b1;
      k_target = 32'h8000_0100;
      tick();
      k_flush = 1'b0;
      wait_req("t3", t, seen);
      chk("t3_addr", imem_req_addr, 32'h8000_0100);
      chk("t3_dropped", seen, 1'b0);
      wait_valid("t3", t, seen);
      chk("t3_id_pc", id_pc, 32'h8000_0100);
      chk("t3_id_instr", id_instr, mem_word(32'h8000_0100));

      // Flush while the request is stalled by the memory
      k_lat = 0;
      tick();
      k_req_ready = 1'b0;
      wait_req("t4a", t, seen);
      a0 = imem_req_addr;
      chk("t4_addr0", a0, 32'h8000_0104);
      k_flush  = 1'b1;
      k_target = 32'h8000_0200;
      tick();
      k_flush = 1'b0;
      repeat (2) tick();
      chk("t4_stable", {imem_req_valid, imem_req_addr}, {1'b1, a0});
      k_req_ready = 1'b1;
      tick();
      wait_req("t4", t, seen);
      chk("t4_addr", imem_req_addr, 32'h8000_0200);
      chk("t4_dropped", seen, 1'b0);
      wait_valid("t4", t, seen);
      chk("t4_id_pc", id_pc, 32'h8000_0200);

      // Jump to a misaligned target while decode is taking the current instruction
      flush    = 1'b1;
      id_ready = 1'b1;
      #1;
      chk("t5_no_adv", pc_adv, 1'b0);
      k_flush  = 1'b1;
      k_target = 32'h8000_0002;
      tick();
      k_flush = 1'b0;
      wait_valid("t5", t, seen);
      chk("t5_lat", t, 1);
      chk("t5_no_req", seen, 1'b0);
      chk("t5_fault", {id_fault, id_instr, id_pc}, {1'b1, 32'h0, 32'h8000_0002});

      // Access fault on the response
      k_flush  = 1'b1;
      k_target = 32'h8000_001C;
      tick();
      k_flush = 1'b0;
      wait_valid("t6", t, seen);
      chk("t6_fault", id_fault, 1'b1);
      chk("t6_instr", id_instr, mem_word(32'h8000_001C));
      tick();

      // Reset in WAIT, then a stray response right after reset
      k_lat = 3;
      wait_req("t6b", t, seen);
      tick();
      rst      = 1'b1;
      mem_busy = 1'b0;
      req_pend = 1'b0;
      mem_addr = 32'hDEAD_BEE0;
      @(posedge clk);
      @(negedge clk);
      chk("t6_rst_flags", {pc_adv, imem_req_valid, id_valid, id_fault}, 4'h0);
      chk("t6_rst_addr", imem_req_addr, 32'h0);
      chk("t6_rst_id", {id_pc, id_instr}, 64'h0);
      rst     = 1'b0;
      k_lat   = 0;
      k_stray = 1'b1;
      tick();
      k_stray = 1'b0;
      wait_valid("t6c", t, seen);
      chk("t6_after_pc", id_pc, 32'h8000_0020);
      chk("t6_after_instr", id_instr, mem_word(32'h8000_0020));

      // Randomized traffic
      n_hand     = 0;
      since_hand = 0;
      for (int i = 0; i < 4000; i++) begin
         k_flush  = ($urandom_range(0, 15) == 0);
         k_target = 32'h8000_0000 + (32'($urandom_range(0, 1023)) << 2);
         if ($urandom_range(0, 7) == 0) k_target[1:0] = 2'($urandom_range(1, 3));
         k_id_ready  = ($urandom_range(0, 2) != 0);
         k_req_ready = 1'($urandom_range(0, 1));
         k_lat       = $urandom_range(0, 3);
         tick();
         if (since_hand > 200) begin
            chk("progress_stall", since_hand, 0);
            break;
         end
      end
      chk("rand_handoffs", (n_hand > 100), 1'b1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
`default_nettype wire
